wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (the MEM/WB stage output) and a long-latency unit (mul/div) result channel.
- Pipeline writeback normally has priority. A displaced long-latency result waits in a 1-entry buffer.
- A starvation counter forces a one-cycle pipeline stall so the buffer can drain.
- Sits between the MEM/WB register / writeback mux and the register file write port.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
MAX_WAIT, 4, cycles a buffered result may be displaced before stall_req asserts (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wb_valid  in  1  pipeline writeback request this cycle
wb_waddr  in  ADDR_W  pipeline destination register
wb_wdata  in  DATA_W  pipeline writeback data (result or load data, already muxed)
lu_valid  in  1  long-latency unit result valid
lu_ready  out  1  arbiter can accept lu result
lu_waddr  in  ADDR_W  long-latency destination register
lu_wdata  in  DATA_W  long-latency result data
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  ADDR_W  register-file write address (registered)
rf_wdata  out  DATA_W  register-file write data (registered)
stall_req  out  1  freeze pipeline this cycle; MEM/WB holds its contents

Behaviour:
- Clock and reset: reset, asynchronous, active-high; clock clk.
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Buffer empty, wait_cnt=0, so lu_ready=1 and stall_req=0.
- State: buf_full, buf_addr, buf_data, wait_cnt (4 bits, saturating at MAX_WAIT).
- Combinational outputs:
  - lu_ready = !buf_full.
  - stall_req = buf_full && wait_cnt==MAX_WAIT.
- Definitions:
  - lu accept = lu_valid && lu_ready.
  - wb_req = wb_valid && wb_waddr!=0.
  - Writes to register 0 are never issued: a wb to x0 counts as no request; an lu to x0 is accepted and discarded, never buffered.
- Per-cycle grant priority; the selected write appears on rf_* at the next clk edge (latency 1):
  1. stall_req=1: write the buffer entry; buffer cleared, wait_cnt=0. wb inputs are ignored this cycle; they are re-presented next cycle by the frozen pipeline.
  2. wb_req: write the wb entry. If buf_full, wait_cnt increments (saturating).
  3. buf_full: write the buffer entry; buffer cleared, wait_cnt=0.
  4. lu accept with lu_waddr!=0: bypass, write lu directly; nothing buffered.
  5. Otherwise rf_we=0. rf_waddr and rf_wdata hold their previous values.
- lu accepted in a cycle where case 2 fires: the entry goes into the buffer with wait_cnt=0. It cannot occur in cases 1 or 3, because lu_ready=0 there.
- WAW kill: if wb_req with wb_waddr==buf_addr while buf_full (case 2), the buffer entry is dropped and wait_cnt=0. The younger pipeline write wins. lu_ready rises the following cycle.
- No data loss:
  - Every accepted lu result with addr!=0 is either written or killed by a WAW kill.
  - Every wb_req is written exactly once; stalled cycles do not count.
- Maximum wait from buffering to write: MAX_WAIT+1 cycles.
- Reset mid-operation: a buffered entry is discarded. An in-flight rf write does not occur after reset asserts.

Test Plan:
- Reset then idle: no requests for 10 cycles -> rf_we=0, lu_ready=1, stall_req=0 throughout.
- Bypass: lu_valid, addr 7, data 0xDEAD_BEEF, wb idle -> next cycle rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF, lu_ready stays 1.
- Conflict and drain: wb (addr 3, data 0x11) and lu (addr 9, data 0x22) in the same cycle, wb idle next cycle -> rf writes 3/0x11 then 9/0x22. lu_ready=0 for exactly one cycle.
- Starvation (MAX_WAIT=4): lu addr 5 buffered under continuous wb_req to addr 1 -> stall_req=1 on the 5th displaced cycle. Buffer written (5) that cycle, ignored wb re-presented and written next. lu_ready=1 after.
- WAW kill: buffer holds addr 12, then wb_req addr 12 data 0x55 -> rf writes 12/0x55 only. The buffered value is never written; lu_ready=1 the next cycle.
- x0 and async reset: lu addr 0 -> accepted, rf_we stays 0. Reset asserted mid-cycle while buf_full -> outputs 0 immediately, no buffered write after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between pipeline writeback and a long-latency unit
module wb_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0] lu_wdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall_req
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic              buf_full_q, buf_full_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic wb_req;
    logic lu_live;

    assign lu_ready  = !buf_full_q;
    assign stall_req = buf_full_q && (wait_cnt_q == WAIT_LIMIT);
    assign wb_req    = wb_valid && (wb_waddr != '0);
    // An accepted lu result to x0 is swallowed here: it never reaches the buffer or the port.
    assign lu_live   = lu_valid && !buf_full_q && (lu_waddr != '0);

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    always_comb begin
        buf_full_d = buf_full_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        wait_cnt_d = wait_cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (stall_req) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = buf_addr_q;
            rf_wdata_d = buf_data_q;
            buf_full_d = 1'b0;
            wait_cnt_d = '0;
        end else if (wb_req) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_waddr;
            rf_wdata_d = wb_wdata;
            if (buf_full_q) begin
                // Younger pipeline write to the same register makes the buffered value dead.
                if (wb_waddr == buf_addr_q) begin
                    buf_full_d = 1'b0;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_LIMIT) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end else if (lu_live) begin
                buf_full_d = 1'b1;
                buf_addr_d = lu_waddr;
                buf_data_d = lu_wdata;
                wait_cnt_d = '0;
            end
        end else if (buf_full_q) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = buf_addr_q;
            rf_wdata_d = buf_data_q;
            buf_full_d = 1'b0;
            wait_cnt_d = '0;
        end else if (lu_live) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = lu_waddr;
            rf_wdata_d = lu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full_q <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized and directed bench for wb_port_arbiter against a behavioural model
module tb_wb_port_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wb_valid = 1'b0;
    logic [ADDR_W-1:0] wb_waddr = '0;
    logic [DATA_W-1:0] wb_wdata = '0;
    logic              lu_valid = 1'b0;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_waddr = '0;
    logic [DATA_W-1:0] lu_wdata = '0;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall_req;

    int checks = 0;
    int failures = 0;

    // Reference model: a pending long-latency result and how many cycles it has been displaced.
    bit              m_pending;
    bit [ADDR_W-1:0] m_paddr;
    bit [DATA_W-1:0] m_pdata;
    int              m_age;
    bit              m_we;
    bit [ADDR_W-1:0] m_waddr;
    bit [DATA_W-1:0] m_wdata;
    bit              m_ready;
    bit              m_stall;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pending = 0; m_paddr = '0; m_pdata = '0; m_age = 0;
        m_we = 0; m_waddr = '0; m_wdata = '0;
        m_ready = 1; m_stall = 0;
    endtask

    // Predict the handshake outputs for the current inputs, then advance one clock.
    task automatic model_cycle();
        bit starving, wants_wb, takes_lu;
        starving = m_pending && (m_age >= MAX_WAIT);
        wants_wb = wb_valid && (wb_waddr != 0);
        takes_lu = lu_valid && !m_pending;
        m_ready  = !m_pending;
        m_stall  = starving;
        m_we     = 0;
        if (starving) begin
            m_we = 1; m_waddr = m_paddr; m_wdata = m_pdata;
            m_pending = 0; m_age = 0;
        end else if (wants_wb) begin
            m_we = 1; m_waddr = wb_waddr; m_wdata = wb_wdata;
            if (m_pending && wb_waddr == m_paddr) begin
                m_pending = 0; m_age = 0;
            end else if (m_pending) begin
                m_age = (m_age + 1 > MAX_WAIT) ? MAX_WAIT : m_age + 1;
            end else if (takes_lu && lu_waddr != 0) begin
                m_pending = 1; m_paddr = lu_waddr; m_pdata = lu_wdata; m_age = 0;
            end
        end else if (m_pending) begin
            m_we = 1; m_waddr = m_paddr; m_wdata = m_pdata;
            m_pending = 0; m_age = 0;
        end else if (takes_lu && lu_waddr != 0) begin
            m_we = 1; m_waddr = lu_waddr; m_wdata = lu_wdata;
        end
    endtask

    task automatic drive(input bit wv, input int wa, input int wd, input bit lv, input int la, input int ld);
        wb_valid = wv; wb_waddr = ADDR_W'(wa); wb_wdata = DATA_W'(wd);
        lu_valid = lv; lu_waddr = ADDR_W'(la); lu_wdata = DATA_W'(ld);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++;
            if (lu_ready !== 1'b1 || stall_req !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_hs: lu_ready=%0b stall_req=%0b expected 1/0", lu_ready, stall_req);
            end
            model_cycle();
            tick();
            checks++;
            if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
                failures++;
                $display("FAIL reset_idle_rf: we=%0b addr=%0d data=%0h expected 0/0/0", rf_we, rf_waddr, rf_wdata);
            end
        end
    endtask

    task automatic test_bypass();
        drive(0, 0, 0, 1, 7, 32'hDEAD_BEEF);
        model_cycle();
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEAD_BEEF || lu_ready !== 1'b1) begin
            failures++;
            $display("FAIL bypass: we=%0b addr=%0d data=%0h ready=%0b expected 1/7/deadbeef/1", rf_we, rf_waddr, rf_wdata, lu_ready);
        end
        model_cycle();
        tick();
    endtask

    task automatic test_conflict();
        drive(1, 3, 32'h11, 1, 9, 32'h22);
        model_cycle();
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11 || lu_ready !== 1'b0) begin
            failures++;
            $display("FAIL conflict_first: we=%0b addr=%0d data=%0h ready=%0b expected 1/3/11/0", rf_we, rf_waddr, rf_wdata, lu_ready);
        end
        model_cycle();
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h22 || lu_ready !== 1'b1) begin
            failures++;
            $display("FAIL conflict_drain: we=%0b addr=%0d data=%0h ready=%0b expected 1/9/22/1", rf_we, rf_waddr, rf_wdata, lu_ready);
        end
        model_cycle();
        tick();
    endtask

    task automatic test_starvation();
        drive(1, 1, 32'h100, 1, 5, 32'h5555);
        model_cycle();
        tick();
        for (int c = 1; c <= MAX_WAIT; c++) begin
            drive(1, 1, 32'h100 + c, 0, 0, 0);
            checks++;
            if (stall_req !== 1'b0 || lu_ready !== 1'b0) begin
                failures++;
                $display("FAIL starve_wait%0d: stall=%0b ready=%0b expected 0/0", c, stall_req, lu_ready);
            end
            model_cycle();
            tick();
        end
        drive(1, 1, 32'h1FF, 0, 0, 0);
        checks++;
        if (stall_req !== 1'b1) begin
            failures++;
            $display("FAIL starve_stall: stall_req=%0b expected 1", stall_req);
        end
        model_cycle();
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h5555) begin
            failures++;
            $display("FAIL starve_buf_write: we=%0b addr=%0d data=%0h expected 1/5/5555", rf_we, rf_waddr, rf_wdata);
        end
        drive(1, 1, 32'h1FF, 0, 0, 0);
        checks++;
        if (stall_req !== 1'b0 || lu_ready !== 1'b1) begin
            failures++;
            $display("FAIL starve_release: stall=%0b ready=%0b expected 0/1", stall_req, lu_ready);
        end
        model_cycle();
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h1FF) begin
            failures++;
            $display("FAIL starve_represent: we=%0b addr=%0d data=%0h expected 1/1/1ff", rf_we, rf_waddr, rf_wdata);
        end
        drive(0, 0, 0, 0, 0, 0);
        model_cycle();
        tick();
    endtask

    task automatic test_waw_kill();
        drive(1, 2, 32'hAA, 1, 12, 32'h77);
        model_cycle();
        tick();
        drive(1, 12, 32'h55, 0, 0, 0);
        model_cycle();
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h55) begin
            failures++;
            $display("FAIL waw_write: we=%0b addr=%0d data=%0h expected 1/12/55", rf_we, rf_waddr, rf_wdata);
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (lu_ready !== 1'b1) begin
            failures++;
            $display("FAIL waw_ready: lu_ready=%0b expected 1", lu_ready);
        end
        model_cycle();
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL waw_no_stale: rf_we=%0b expected 0", rf_we);
        end
    endtask

    task automatic test_x0();
        drive(0, 0, 0, 1, 0, 32'h1234);
        checks++;
        if (lu_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_ready: lu_ready=%0b expected 1", lu_ready);
        end
        model_cycle();
        tick();
        drive(1, 0, 32'h99, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b0 || lu_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_lu: rf_we=%0b ready=%0b expected 0/1", rf_we, lu_ready);
        end
        model_cycle();
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL x0_wb: rf_we=%0b expected 0", rf_we);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 4, 32'h44, 1, 6, 32'h66);
        model_cycle();
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || lu_ready !== 1'b1 || stall_req !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: we=%0b addr=%0d data=%0h ready=%0b stall=%0b expected 0/0/0/1/0",
                     rf_we, rf_waddr, rf_wdata, lu_ready, stall_req);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            model_cycle();
            tick();
            checks++;
            if (rf_we !== 1'b0) begin
                failures++;
                $display("FAIL async_reset_nowrite%0d: rf_we=%0b expected 0", i, rf_we);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 9) < 7), $urandom_range(0, 7), $urandom,
                  ($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom);
            model_cycle();
            checks++;
            if (lu_ready !== m_ready || stall_req !== m_stall) begin
                failures++;
                $display("FAIL rand_hs@%0d: ready=%0b stall=%0b expected %0b/%0b", i, lu_ready, stall_req, m_ready, m_stall);
            end
            tick();
            checks++;
            if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                failures++;
                $display("FAIL rand_rf@%0d: we=%0b addr=%0d data=%0h expected %0b/%0d/%0h",
                         i, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bypass();
        test_conflict();
        test_starvation();
        test_waw_kill();
        test_x0();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
